t64_cag444torgb888_k8_mul_pipe: RTL and testbench

T64_CAG444TORGB888_K8_MUL_PIPE -- requirements
Module: t64_cag444torgb888_k8_mul_pipe

---
 rtl/t64_cag444torgb888_k8_mul_pipe.sv | 119 +++++++++++
 tb/tb_t64_cag444torgb888_k8_mul_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t64_cag444torgb888_k8_mul_pipe.sv
// Multi-lane signed x unsigned multiplier with rounding shift, truncate/saturate/clamp
// output stage, and a stallable valid-tagged pipeline of NUM_STAGE registers.

module t64_cag444torgb888_k8_mul_lane #(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 18,
  parameter int SHIFT      = 0,
  parameter int MODE       = 0
) (
  input  logic signed [DIN0_WIDTH-1:0] a,
  input  logic        [DIN1_WIDTH-1:0] b,
  output logic        [DOUT_WIDTH-1:0] res,
  output logic                         sat
);
  localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int XW = (P + 1 > DOUT_WIDTH + 1) ? P + 1 : DOUT_WIDTH + 1;
  localparam logic [P:0] HALF = {{P{1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0);
  localparam logic signed [XW-1:0] SMAX = {{(XW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = ~SMAX;
  localparam logic signed [XW-1:0] UMAX = {{(XW-DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};

  logic signed [P:0]    ax, bx, prod, rnd, shd;
  logic signed [XW-1:0] v;

  // one spare bit so the rounding add can never wrap
  assign ax   = {{(DIN1_WIDTH+1){a[DIN0_WIDTH-1]}}, a};
  assign bx   = {{(DIN0_WIDTH+1){1'b0}}, b};
  assign prod = ax * bx;
  assign rnd  = (SHIFT > 0) ? prod + $signed(HALF) : prod;
  assign shd  = rnd >>> SHIFT;
  assign v    = XW'(shd);

  always_comb begin
    res = v[DOUT_WIDTH-1:0];
    sat = 1'b0;
    case (MODE)
      1: begin
        if (v > SMAX)      begin res = SMAX[DOUT_WIDTH-1:0]; sat = 1'b1; end
        else if (v < SMIN) begin res = SMIN[DOUT_WIDTH-1:0]; sat = 1'b1; end
      end
      2: begin
        if (v < 0)         begin res = '0; sat = 1'b1; end
        else if (v > UMAX) begin res = '1; sat = 1'b1; end
      end
      default: ;
    endcase
  end
endmodule

module t64_cag444torgb888_k8_mul_pipe #(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 18,
  parameter int LANES      = 3,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int MODE       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DIN0_WIDTH-1:0]  din0,
  input  logic [LANES*DIN1_WIDTH-1:0]  din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*DOUT_WIDTH-1:0]  dout,
  output logic [LANES-1:0]             sat
);
  logic                                          advance;
  logic [LANES*DOUT_WIDTH-1:0]                   res;
  logic [LANES-1:0]                              res_sat;
  logic [NUM_STAGE:1]                            vld_pipe;
  logic [NUM_STAGE:1][LANES*DOUT_WIDTH-1:0]      dat_pipe;
  logic [NUM_STAGE:1][LANES-1:0]                 sat_pipe;

  assign advance  = ce & ~(out_valid & ~out_ready);
  assign in_ready = advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    t64_cag444torgb888_k8_mul_lane #(
      .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH),
      .SHIFT(SHIFT), .MODE(MODE)
    ) u_lane (
      .a   (din0[i*DIN0_WIDTH +: DIN0_WIDTH]),
      .b   (din1[i*DIN1_WIDTH +: DIN1_WIDTH]),
      .res (res[i*DOUT_WIDTH +: DOUT_WIDTH]),
      .sat (res_sat[i])
    );
  end

  // data only follows valid beats, so dout keeps the last delivered result across bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      sat_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        dat_pipe[1] <= res;
        sat_pipe[1] <= res_sat;
      end
      for (int s = 2; s <= NUM_STAGE; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          sat_pipe[s] <= sat_pipe[s-1];
        end
      end
    end
  end

  assign out_valid = vld_pipe[NUM_STAGE];
  assign dout      = dat_pipe[NUM_STAGE];
  assign sat       = sat_pipe[NUM_STAGE];
endmodule

// File: tb/tb_t64_cag444torgb888_k8_mul_pipe.sv
// Bench for t64_cag444torgb888_k8_mul_pipe: five parameterisations share one stimulus
// stream; each has its own expected-result queue filled on accept, drained on delivery.

module tb_t64_cag444torgb888_k8_mul_pipe;
  localparam int N = 5;
  localparam int CDW [N] = '{18, 8, 20, 8, 9};
  localparam int CSH [N] = '{0, 8, 4, 6, 0};
  localparam int CMD [N] = '{0, 2, 0, 1, 0};
  localparam int CL  [N] = '{3, 3, 1, 3, 2};

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, out_ready;
  logic [23:0] din0;
  logic [29:0] din1;
  logic [N-1:0] rdy, ov;
  logic [63:0] dout_w [N];
  logic [2:0]  sat_w  [N];
  logic [53:0] dout_a;
  logic [23:0] dout_b, dout_d;
  logic [19:0] dout_c;
  logic [17:0] dout_e;
  logic        sat_c;
  logic [1:0]  sat_e;

  exp_t q [N][$];
  exp_t mon_e;
  int   npop [N];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  t64_cag444torgb888_k8_mul_pipe u_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(dout_a), .sat(sat_w[0]));

  t64_cag444torgb888_k8_mul_pipe #(.DOUT_WIDTH(8), .SHIFT(8), .MODE(2), .NUM_STAGE(3)) u_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(dout_b), .sat(sat_w[1]));

  t64_cag444torgb888_k8_mul_pipe #(.DOUT_WIDTH(20), .SHIFT(4), .MODE(0), .LANES(1),
                                   .NUM_STAGE(1)) u_c (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[2]),
    .din0(din0[7:0]), .din1(din1[9:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(dout_c), .sat(sat_c));

  t64_cag444torgb888_k8_mul_pipe #(.DOUT_WIDTH(8), .SHIFT(6), .MODE(1), .NUM_STAGE(4)) u_d (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[3]),
    .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready),
    .dout(dout_d), .sat(sat_w[3]));

  t64_cag444torgb888_k8_mul_pipe #(.DOUT_WIDTH(9), .SHIFT(0), .MODE(0), .LANES(2),
                                   .NUM_STAGE(3)) u_e (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[4]),
    .din0(din0[15:0]), .din1(din1[19:0]), .out_valid(ov[4]), .out_ready(out_ready),
    .dout(dout_e), .sat(sat_e));

  assign dout_w[0] = 64'(dout_a);
  assign dout_w[1] = 64'(dout_b);
  assign dout_w[2] = 64'(dout_c);
  assign dout_w[3] = 64'(dout_d);
  assign dout_w[4] = 64'(dout_e);
  assign sat_w[2]  = {2'b00, sat_c};
  assign sat_w[4]  = {1'b0, sat_e};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product, round half up, then truncate / saturate / clamp.
  function automatic longint lane_ref(input longint a, input longint b, input int dw,
                                      input int sh, input int md, output logic s);
    longint p, mx, mn;
    p = a * b;
    if (sh > 0) p = (p + (64'sd1 <<< (sh - 1))) >>> sh;
    s = 1'b0;
    mx = 0;
    mn = 0;
    if (md == 1) begin
      mx = (64'sd1 <<< (dw - 1)) - 1;
      mn = -(64'sd1 <<< (dw - 1));
    end else if (md == 2) begin
      mx = (64'sd1 <<< dw) - 1;
      mn = 0;
    end
    if (md != 0) begin
      if (p > mx)      begin p = mx; s = 1'b1; end
      else if (p < mn) begin p = mn; s = 1'b1; end
    end
    return p & ((64'sd1 <<< dw) - 1);
  endfunction

  function automatic exp_t mk(input int k);
    exp_t              e;
    logic signed [7:0] a8;
    logic [9:0]        b10;
    logic              sl;
    longint            r;
    e = '0;
    for (int l = 0; l < CL[k]; l++) begin
      a8  = din0[l*8 +: 8];
      b10 = din1[l*10 +: 10];
      r   = lane_ref(longint'(a8), longint'({1'b0, b10}), CDW[k], CSH[k], CMD[k], sl);
      e.d = e.d | (64'(r) << (l * CDW[k]));
      e.s[l] = sl;
    end
    return e;
  endfunction

  // Inputs change #1 after posedge, so negedge shows what the next edge will do.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (ov[k] && out_ready && ce) begin
          if (q[k].size() == 0) chk($sformatf("dut%0d_spurious_out", k), 64'd1, 64'd0);
          else begin
            mon_e = q[k].pop_front();
            chk($sformatf("dut%0d_dout", k), dout_w[k], mon_e.d);
            chk($sformatf("dut%0d_sat", k), 64'(sat_w[k]), 64'(mon_e.s));
            npop[k]++;
          end
        end
        if (in_valid && rdy[k]) q[k].push_back(mk(k));
      end
    end
  end

  initial begin
    int   i, cyc, base;
    logic acc;
    logic [N-1:0] snap_ov;
    logic [63:0]  snap_d;

    for (int k = 0; k < N; k++) npop[k] = 0;
    reset = 1'b1; ce = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; din0 = 24'h123456; din1 = 30'h0abcdef;

    // reset state, in_ready follows ce, beats offered in reset are dropped
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov), 64'd0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_dout%0d", k), dout_w[k], 64'd0);
      chk($sformatf("rst_sat%0d", k), 64'(sat_w[k]), 64'd0);
    end
    chk("rst_in_ready_ce1", 64'(rdy), 64'h1f);
    ce = 1'b0;
    #1 chk("rst_in_ready_ce0", 64'(rdy), 64'd0);
    ce = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("no_capture_in_reset", 64'(ov), 64'd0);

    // -128 * 1023 on lane 0, default config
    @(posedge clk); #1;
    din0 = {8'd0, 8'd0, 8'h80}; din1 = {10'd0, 10'd0, 10'd1023}; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("lat_a_not_yet", 64'(ov[0]), 64'd0);
    @(negedge clk);
    chk("ex1_valid", 64'(ov[0]), 64'd1);
    chk("ex1_dout_lane0", 64'(dout_a[17:0]), 64'h20080);
    chk("ex1_sat_lane0", 64'(sat_w[0][0]), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // unsigned clamp corners on the 8-bit / shift-8 instance
    din0 = {8'd1, 8'hfb, 8'd100}; din1 = {10'd384, 10'd300, 10'd700}; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ex2_valid", 64'(ov[1]), 64'd1);
    chk("ex2_dout", dout_w[1], 64'h0200ff);
    chk("ex2_sat", 64'(sat_w[1]), 64'b011);
    repeat (4) @(posedge clk);
    #1;

    // 16 back-to-back beats with out_ready low for stream cycles 3..6
    base = npop[0]; i = 0; cyc = 0;
    din0 = 24'($urandom); din1 = 30'($urandom); in_valid = 1'b1;
    while (i < 16 && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      if (cyc >= 3 && cyc <= 6) chk("stall_in_ready", 64'(rdy[0]), 64'd0);
      else                      chk("run_in_ready", 64'(rdy[0]), 64'd1);
      acc = rdy[0];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin i++; din0 = 24'($urandom); din1 = 30'($urandom); end
    end
    chk("stream_accepted", 64'(i), 64'd16);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("stream_delivered", 64'(npop[0] - base), 64'd16);

    // clock-enable freeze mid-stream
    in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1 din0 = 24'($urandom); din1 = 30'($urandom); end
    snap_ov = ov; snap_d = dout_w[0];
    chk("freeze_pre_ov", 64'(ov[0]), 64'd1);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("freeze_ov", 64'(ov), 64'(snap_ov));
      chk("freeze_dout", dout_w[0], snap_d);
      chk("freeze_in_ready", 64'(rdy), 64'd0);
    end
    @(posedge clk); #1 ce = 1'b1;
    repeat (4) begin @(posedge clk); #1 din0 = 24'($urandom); din1 = 30'($urandom); end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // async reset with two beats in flight
    din0 = 24'($urandom); din1 = 30'($urandom); in_valid = 1'b1;
    @(posedge clk); #1 din0 = 24'($urandom); din1 = 30'($urandom);
    @(posedge clk); #1;
    chk("rst2_pre_ov", 64'(ov[0]), 64'd1);
    in_valid = 1'b0; reset = 1'b1;
    for (int k = 0; k < N; k++) q[k].delete();
    #1;
    chk("rst2_ov", 64'(ov), 64'd0);
    for (int k = 0; k < N; k++) chk($sformatf("rst2_dout%0d", k), dout_w[k], 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk) chk("rst2_no_stale", 64'(ov), 64'd0);
    @(posedge clk); #1;
    din0 = 24'($urandom); din1 = 30'($urandom); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("post_rst_lat1", 64'(ov[0]), 64'd0);
    @(negedge clk) chk("post_rst_lat2", 64'(ov[0]), 64'd1);

    // random sweep with random backpressure and clock-enable gaps
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      din0      = 24'($urandom);
      din1      = 30'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      ce        = ($urandom_range(0, 9) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
